// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scanner.
// Contents:
//   SEG_W        segment bus width (a..g)
//   SEG_A..SEG_G one-hot masks giving the bit position of each segment in {g..a}
//   hex2seg()    nibble -> active-high segment pattern {g..a}, glyphs 0-9, A, b, C, d, E, F
package seg7_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_A = 7'b000_0001;
  localparam logic [SEG_W-1:0] SEG_B = 7'b000_0010;
  localparam logic [SEG_W-1:0] SEG_C = 7'b000_0100;
  localparam logic [SEG_W-1:0] SEG_D = 7'b000_1000;
  localparam logic [SEG_W-1:0] SEG_E = 7'b001_0000;
  localparam logic [SEG_W-1:0] SEG_F = 7'b010_0000;
  localparam logic [SEG_W-1:0] SEG_G = 7'b100_0000;

  function automatic logic [SEG_W-1:0] hex2seg(input logic [3:0] nib);
    logic [SEG_W-1:0] seg;
    case (nib)
      4'h0:    seg = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F;
      4'h1:    seg = SEG_B | SEG_C;
      4'h2:    seg = SEG_A | SEG_B | SEG_D | SEG_E | SEG_G;
      4'h3:    seg = SEG_A | SEG_B | SEG_C | SEG_D | SEG_G;
      4'h4:    seg = SEG_B | SEG_C | SEG_F | SEG_G;
      4'h5:    seg = SEG_A | SEG_C | SEG_D | SEG_F | SEG_G;
      4'h6:    seg = SEG_A | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
      4'h7:    seg = SEG_A | SEG_B | SEG_C;
      4'h8:    seg = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
      4'h9:    seg = SEG_A | SEG_B | SEG_C | SEG_D | SEG_F | SEG_G;
      4'hA:    seg = SEG_A | SEG_B | SEG_C | SEG_E | SEG_F | SEG_G;
      4'hB:    seg = SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;
      4'hC:    seg = SEG_A | SEG_D | SEG_E | SEG_F;
      4'hD:    seg = SEG_B | SEG_C | SEG_D | SEG_E | SEG_G;
      4'hE:    seg = SEG_A | SEG_D | SEG_E | SEG_F | SEG_G;
      default: seg = SEG_A | SEG_E | SEG_F | SEG_G;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Scan timebase for seg7_scan_ctrl.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   o_slot_cnt       cycle position inside the current digit slot (0..SLOT_CYCLES-1)
//   o_digit_idx      digit currently being scanned (0..NUM_DIGITS-1)
//   o_pwm_cnt        free-running brightness PWM counter
//   o_blink_phase    1 while blinking digits are in their dark half-period
//   o_frame_bound    combinational: this cycle is the frame boundary (slot 0 of digit 0)
//   o_frame_start    frame_bound delayed one cycle, aligned with the registered pins
module seg7_scan_timer
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYCLES  = 6250,
  parameter int BRIGHT_W     = 3,
  parameter int BLINK_FRAMES = 512,
  parameter int SLOT_W       = 13,
  parameter int IDX_W        = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [SLOT_W-1:0]   o_slot_cnt,
  output logic [IDX_W-1:0]    o_digit_idx,
  output logic [BRIGHT_W-1:0] o_pwm_cnt,
  output logic                o_blink_phase,
  output logic                o_frame_bound,
  output logic                o_frame_start
);

  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  logic [SLOT_W-1:0]   r_slot_cnt;
  logic [IDX_W-1:0]    r_digit_idx;
  logic [BRIGHT_W-1:0] r_pwm_cnt;
  logic [BLINK_W-1:0]  r_blink_cnt;
  logic                r_blink_phase;
  logic                r_frame_start;
  logic                w_frame_bound;

  assign w_frame_bound = (r_slot_cnt == '0) && (r_digit_idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_cnt    <= '0;
      r_digit_idx   <= '0;
      r_pwm_cnt     <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      // PWM runs independently of the slot counter so the duty pattern
      // is uniform across the whole lit window.
      r_pwm_cnt     <= r_pwm_cnt + 1'b1;
      r_frame_start <= w_frame_bound;
      if (r_slot_cnt == SLOT_LAST) begin
        r_slot_cnt  <= '0;
        r_digit_idx <= (r_digit_idx == IDX_LAST) ? '0 : r_digit_idx + 1'b1;
      end else begin
        r_slot_cnt  <= r_slot_cnt + 1'b1;
      end
      // Blink phase advances only on frame boundaries, so a digit is never
      // cut off part-way through its slot.
      if (w_frame_bound) begin
        if (r_blink_cnt == BLINK_LAST) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_blink_cnt   <= r_blink_cnt + 1'b1;
        end
      end
    end
  end

  assign o_slot_cnt    = r_slot_cnt;
  assign o_digit_idx   = r_digit_idx;
  assign o_pwm_cnt     = r_pwm_cnt;
  assign o_blink_phase = r_blink_phase;
  assign o_frame_bound = w_frame_bound;
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   upd_valid_i      new display image offered
//   upd_ready_o      pending buffer empty; image can be accepted
//   hex_i            nibble per digit, digit 0 in the LSBs (rightmost)
//   raw_seg_i        raw active-high {g..a} per digit, used when raw_mode_i
//   raw_mode_i       1: raw_seg_i drives segments, 0: hex_i is decoded
//   dp_i             decimal point per digit, active high
//   en_i             digit enable; 0 keeps that anode off
//   blink_i          digit blinks when 1
//   bright_i         brightness, 0 = dark, all-ones = full on
//   seg_n_o          {cg..ca}, active low
//   dp_n_o           decimal point, active low
//   an_n_o           anodes, active low
//   frame_start_o    1-cycle pulse when the digit 0 slot begins
// An accepted image waits in the pending buffer and is copied to the active
// buffer only at a frame boundary, so a frame is never drawn from two images.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 4,
  parameter int BRIGHT_W     = 3,
  parameter int BLINK_FRAMES = 512
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        upd_valid_i,
  output logic                        upd_ready_o,
  input  logic [4*NUM_DIGITS-1:0]     hex_i,
  input  logic [SEG_W*NUM_DIGITS-1:0] raw_seg_i,
  input  logic                        raw_mode_i,
  input  logic [NUM_DIGITS-1:0]       dp_i,
  input  logic [NUM_DIGITS-1:0]       en_i,
  input  logic [NUM_DIGITS-1:0]       blink_i,
  input  logic [BRIGHT_W-1:0]         bright_i,
  output logic [SEG_W-1:0]            seg_n_o,
  output logic                        dp_n_o,
  output logic [NUM_DIGITS-1:0]       an_n_o,
  output logic                        frame_start_o
);

  localparam int SLOT_CYCLES = CLK_FREQ_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int SLOT_W      = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SLOT_W-1:0] LIT_START = SLOT_W'(BLANK_CYCLES);

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_digits
      $error("seg7_scan_ctrl: NUM_DIGITS must be in 1..16");
    end
    if (SLOT_CYCLES < BLANK_CYCLES + 2**BRIGHT_W) begin : g_bad_slot
      $error("seg7_scan_ctrl: digit slot too short for blanking plus one PWM period");
    end
  endgenerate

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0]     hex;
    logic [SEG_W*NUM_DIGITS-1:0] raw;
    logic                        raw_mode;
    logic [NUM_DIGITS-1:0]       dp;
    logic [NUM_DIGITS-1:0]       en;
    logic [NUM_DIGITS-1:0]       blink;
    logic [BRIGHT_W-1:0]         bright;
  } image_t;

  image_t              r_pend;
  image_t              r_act;
  logic                r_pend_full;
  image_t              w_in;

  logic [SLOT_W-1:0]   w_slot_cnt;
  logic [IDX_W-1:0]    w_digit_idx;
  logic [BRIGHT_W-1:0] w_pwm_cnt;
  logic                w_blink_phase;
  logic                w_frame_bound;

  logic [3:0]          w_nib;
  logic [SEG_W-1:0]    w_raw;
  logic                w_dp;
  logic                w_en;
  logic                w_blink;
  logic                w_pwm_on;
  logic                w_lit;
  logic [SEG_W-1:0]    w_seg;
  logic [NUM_DIGITS-1:0] w_an_n;

  logic [SEG_W-1:0]      r_seg_n;
  logic                  r_dp_n;
  logic [NUM_DIGITS-1:0] r_an_n;

  seg7_scan_timer #(
    .NUM_DIGITS   (NUM_DIGITS),
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BRIGHT_W     (BRIGHT_W),
    .BLINK_FRAMES (BLINK_FRAMES),
    .SLOT_W       (SLOT_W),
    .IDX_W        (IDX_W)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_slot_cnt    (w_slot_cnt),
    .o_digit_idx   (w_digit_idx),
    .o_pwm_cnt     (w_pwm_cnt),
    .o_blink_phase (w_blink_phase),
    .o_frame_bound (w_frame_bound),
    .o_frame_start (frame_start_o)
  );

  assign w_in = {hex_i, raw_seg_i, raw_mode_i, dp_i, en_i, blink_i, bright_i};

  // Moving pending to active takes priority on the boundary cycle. An offer
  // arriving on that same cycle can only be taken if pending was already
  // empty, so it lands in pending and waits for the following boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= '0;
      r_act       <= '0;
      r_pend_full <= 1'b0;
    end else if (w_frame_bound && r_pend_full) begin
      r_act       <= r_pend;
      r_pend_full <= 1'b0;
    end else if (upd_valid_i && !r_pend_full) begin
      r_pend      <= w_in;
      r_pend_full <= 1'b1;
    end
  end

  assign upd_ready_o = ~r_pend_full;

  always_comb begin
    w_nib   = '0;
    w_raw   = '0;
    w_dp    = 1'b0;
    w_en    = 1'b0;
    w_blink = 1'b0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (w_digit_idx == IDX_W'(d)) begin
        w_nib   = r_act.hex[4*d +: 4];
        w_raw   = r_act.raw[SEG_W*d +: SEG_W];
        w_dp    = r_act.dp[d];
        w_en    = r_act.en[d];
        w_blink = r_act.blink[d];
      end
    end
  end

  // All-ones brightness forces the digit fully on, closing the one-cycle gap
  // that pwm_cnt < bright alone would leave.
  assign w_pwm_on = (r_act.bright == '1) || (w_pwm_cnt < r_act.bright);
  assign w_lit    = (w_slot_cnt >= LIT_START) && w_en && w_pwm_on &&
                    !(w_blink && w_blink_phase);
  assign w_seg    = r_act.raw_mode ? w_raw : hex2seg(w_nib);

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
      assign w_an_n[gi] = ~(w_lit && (w_digit_idx == IDX_W'(gi)));
    end
  endgenerate

  // Pins are registered so every output changes on the same edge; with the
  // blanking window this keeps the previous digit's segments from ghosting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_n <= '1;
      r_dp_n  <= 1'b1;
      r_an_n  <= '1;
    end else begin
      r_an_n  <= w_an_n;
      r_seg_n <= w_lit ? ~w_seg : '1;
      r_dp_n  <= w_lit ? ~w_dp : 1'b1;
    end
  end

  assign seg_n_o = r_seg_n;
  assign dp_n_o  = r_dp_n;
  assign an_n_o  = r_an_n;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

  typedef struct packed {
    logic [15:0] hex;
    logic [27:0] raw;
    logic        raw_mode;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [3:0]  blink;
    logic [2:0]  bright;
  } img_t;

  typedef struct {
    logic [15:0] hex;
    logic [27:0] raw;
    logic        raw_mode;
    logic [3:0]  dp;
    logic [3:0]  en;
    int          dig;
    int          slot;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        upd_valid_i = 1'b0;
  logic        upd_ready_o;
  logic [15:0] hex_i = '0;
  logic [27:0] raw_seg_i = '0;
  logic        raw_mode_i = 1'b0;
  logic [3:0]  dp_i = '0;
  logic [3:0]  en_i = '0;
  logic [3:0]  blink_i = '0;
  logic [2:0]  bright_i = '0;
  logic [6:0]  seg_n_o;
  logic        dp_n_o;
  logic [3:0]  an_n_o;
  logic        frame_start_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: m_t is the scan time (cycles since reset release)
  // that the next clock edge will consume.
  int   m_t    = 0;
  img_t m_act  = '0;
  img_t m_pend = '0;
  bit   m_full = 1'b0;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (4),
    .CLK_FREQ_HZ  (8000),
    .REFRESH_HZ   (100),
    .BLANK_CYCLES (4),
    .BRIGHT_W     (3),
    .BLINK_FRAMES (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .upd_valid_i   (upd_valid_i),
    .upd_ready_o   (upd_ready_o),
    .hex_i         (hex_i),
    .raw_seg_i     (raw_seg_i),
    .raw_mode_i    (raw_mode_i),
    .dp_i          (dp_i),
    .en_i          (en_i),
    .blink_i       (blink_i),
    .bright_i      (bright_i),
    .seg_n_o       (seg_n_o),
    .dp_n_o        (dp_n_o),
    .an_n_o        (an_n_o),
    .frame_start_o (frame_start_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Expected pins {frame_start, an_n[3:0], seg_n[6:0], dp_n} after the edge
  // that consumes scan time t, given the image active during that time.
  // 20-cycle slots, 4 digits, 80-cycle frames, 8-step PWM, blink flips every 2 frames.
  function automatic logic [12:0] model_pins(input int t, input img_t a);
    int slot, dig, pwm, nb;
    bit phase, lit;
    logic [27:0] rs;
    logic [15:0] hx;
    logic [6:0]  seg;
    logic [3:0]  an;
    slot  = t % 20;
    dig   = (t / 20) % 4;
    pwm   = t % 8;
    nb    = (t + 79) / 80;              // boundaries already behind us
    phase = ((nb / 2) % 2) == 1;
    lit   = (slot >= 4) && a.en[dig] && (a.bright == 3'd7 || pwm < int'(a.bright))
            && !(a.blink[dig] && phase);
    rs  = a.raw >> (7 * dig);
    hx  = a.hex >> (4 * dig);
    seg = a.raw_mode ? rs[6:0] : glyph(hx[3:0]);
    an  = 4'hF;
    an[dig] = 1'b0;
    return {(t % 80 == 0), lit ? an : 4'hF, lit ? ~seg : 7'h7F, lit ? ~a.dp[dig] : 1'b1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0d)", name, act, exp, m_t);
    end
  endtask

  function automatic img_t cur_img();
    return {hex_i, raw_seg_i, raw_mode_i, dp_i, en_i, blink_i, bright_i};
  endfunction

  task automatic drive(input img_t im);
    {hex_i, raw_seg_i, raw_mode_i, dp_i, en_i, blink_i, bright_i} = im;
  endtask

  function automatic img_t mk(input logic [15:0] hex, input logic [2:0] bright, input logic [3:0] blink);
    img_t im;
    im = '0;
    im.hex = hex;
    im.en = 4'hF;
    im.bright = bright;
    im.blink = blink;
    return im;
  endfunction

  task automatic tick();
    logic [12:0] e;
    bit er;
    @(posedge clk);
    if (rst_n) begin
      e = model_pins(m_t, m_act);
      if (m_t % 80 == 0 && m_full) begin
        m_act  = m_pend;
        m_full = 1'b0;
      end else if (upd_valid_i && !m_full) begin
        m_pend = cur_img();
        m_full = 1'b1;
      end
      m_t++;
    end else begin
      e = 13'h0FFF;
    end
    er = !m_full;
    #1;
    check("pins", {19'b0, frame_start_o, an_n_o, seg_n_o, dp_n_o}, {19'b0, e});
    check("ready", {31'b0, upd_ready_o}, {31'b0, er});
  endtask

  // Advance until the pins show digit dig, slot position slot (at least one tick).
  task automatic wait_pos(input int dig, input int slot);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 400) begin
      tick();
      n++;
      hit = ((m_t - 1) % 20 == slot) && (((m_t - 1) / 20) % 4 == dig);
    end
    check("wait_pos", {31'b0, hit}, 32'd1);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!upd_ready_o && n < 400) begin
      tick();
      n++;
    end
    check("ready_timeout", {31'b0, upd_ready_o}, 32'd1);
  endtask

  task automatic load(input img_t im);
    drive(im);
    wait_ready();
    upd_valid_i = 1'b1;
    tick();
    upd_valid_i = 1'b0;
    $display("[TB] load hex=%h raw_mode=%0d en=%h blink=%h bright=%0d", im.hex, im.raw_mode, im.en, im.blink, im.bright);
    wait_ready();
  endtask

  task automatic model_reset();
    m_t = 0;
    m_full = 1'b0;
    m_act = '0;
    m_pend = '0;
  endtask

  vec_t vecs[9];

  initial begin
    int cnt, cnt0, cnt1;
    img_t im;

    vecs[0] = '{16'h1234, 28'h0, 1'b0, 4'h0, 4'hF, 0, 4,  7'h19, 1'b1, 4'b1110};
    vecs[1] = '{16'h1234, 28'h0, 1'b0, 4'h0, 4'hF, 3, 19, 7'h79, 1'b1, 4'b0111};
    vecs[2] = '{16'h1234, 28'h0, 1'b0, 4'h0, 4'hF, 0, 3,  7'h7F, 1'b1, 4'b1111};
    vecs[3] = '{16'hC0DE, 28'h0, 1'b0, 4'h2, 4'hF, 1, 10, 7'h21, 1'b0, 4'b1101};
    vecs[4] = '{16'h1234, 28'h0124000, 1'b1, 4'h4, 4'hF, 2, 12, 7'h36, 1'b0, 4'b1011};
    vecs[5] = '{16'h1234, 28'h0, 1'b0, 4'h0, 4'b1011, 2, 12, 7'h7F, 1'b1, 4'b1111};
    vecs[6] = '{16'h0008, 28'h0, 1'b0, 4'h0, 4'hF, 0, 19, 7'h00, 1'b1, 4'b1110};
    vecs[7] = '{16'hF000, 28'h0, 1'b0, 4'h0, 4'hF, 3, 5,  7'h0E, 1'b1, 4'b0111};
    vecs[8] = '{16'h00A0, 28'h0, 1'b0, 4'h0, 4'hF, 1, 8,  7'h08, 1'b1, 4'b1101};

    // Reset state and release
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_an", {28'b0, an_n_o}, 32'hF);
    check("rst_seg", {25'b0, seg_n_o}, 32'h7F);
    check("rst_ready", {31'b0, upd_ready_o}, 32'd1);
    tick();
    check("first_frame_start", {31'b0, frame_start_o}, 32'd1);

    // Table-driven image checks at specific digit/slot positions
    for (int i = 0; i < 9; i++) begin
      im = '0;
      im.hex = vecs[i].hex;
      im.raw = vecs[i].raw;
      im.raw_mode = vecs[i].raw_mode;
      im.dp = vecs[i].dp;
      im.en = vecs[i].en;
      im.bright = 3'd7;
      load(im);
      wait_pos(vecs[i].dig, vecs[i].slot);
      check("vec_seg", {25'b0, seg_n_o}, {25'b0, vecs[i].seg});
      check("vec_dp", {31'b0, dp_n_o}, {31'b0, vecs[i].dp_n});
      check("vec_an", {28'b0, an_n_o}, {28'b0, vecs[i].an});
      $display("[TB] vec %0d digit %0d slot %0d seg_n=%h dp_n=%0d an_n=%b", i, vecs[i].dig, vecs[i].slot, seg_n_o, dp_n_o, an_n_o);
    end

    // Lit window: each digit's anode low for slot cycles 4..19 only
    load(mk(16'h1234, 3'd7, 4'h0));
    wait_pos(0, 0);
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (an_n_o[0] == 1'b0) cnt++;
    end
    check("lit_window", cnt, 16);

    // Offer while not ready is ignored
    wait_pos(1, 0);
    drive(mk(16'h0005, 3'd7, 4'h0));
    upd_valid_i = 1'b1;
    tick();
    check("ready_drop", {31'b0, upd_ready_o}, 32'd0);
    drive(mk(16'h0009, 3'd7, 4'h0));
    repeat (10) tick();
    upd_valid_i = 1'b0;
    wait_ready();
    wait_pos(0, 8);
    check("ignored_offer", {25'b0, seg_n_o}, 32'h12);
    $display("[TB] ignored-offer seq seg_n=%h", seg_n_o);

    // Offer on the boundary cycle applies one frame later
    cnt = 0;
    while (m_t % 80 != 0 && cnt < 200) begin
      tick();
      cnt++;
    end
    drive(mk(16'h0007, 3'd7, 4'h0));
    upd_valid_i = 1'b1;
    tick();
    upd_valid_i = 1'b0;
    check("ready_bound", {31'b0, upd_ready_o}, 32'd0);
    wait_pos(0, 8);
    check("bound_old", {25'b0, seg_n_o}, 32'h12);
    wait_pos(0, 8);
    check("bound_new", {25'b0, seg_n_o}, 32'h78);
    $display("[TB] boundary-offer seq seg_n=%h", seg_n_o);

    // PWM duty: 3/8 of each 16-cycle lit window, then fully dark
    load(mk(16'h1234, 3'd3, 4'h0));
    wait_pos(0, 0);
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (an_n_o != 4'hF) cnt++;
    end
    check("pwm_bright3", cnt, 24);
    load(mk(16'h1234, 3'd0, 4'h0));
    wait_pos(0, 0);
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (an_n_o != 4'hF) cnt++;
    end
    check("pwm_bright0", cnt, 0);
    $display("[TB] pwm seq done");

    // Blink digit 0: dark in two of any four consecutive frames
    load(mk(16'h1234, 3'd7, 4'b0001));
    wait_pos(0, 0);
    cnt0 = 0;
    cnt1 = 0;
    for (int k = 0; k < 320; k++) begin
      tick();
      if (an_n_o[0] == 1'b0) cnt0++;
      if (an_n_o[1] == 1'b0) cnt1++;
    end
    check("blink_digit0", cnt0, 32);
    check("blink_digit1", cnt1, 64);
    $display("[TB] blink seq digit0=%0d digit1=%0d", cnt0, cnt1);

    // Reset mid-frame with an image pending
    load(mk(16'h1234, 3'd7, 4'h0));
    wait_pos(1, 10);
    drive(mk(16'h8888, 3'd7, 4'h0));
    upd_valid_i = 1'b1;
    tick();
    upd_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_an", {28'b0, an_n_o}, 32'hF);
    check("midrst_seg", {25'b0, seg_n_o}, 32'h7F);
    check("midrst_dp", {31'b0, dp_n_o}, 32'd1);
    check("midrst_ready", {31'b0, upd_ready_o}, 32'd1);
    model_reset();
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("midrst_frame_start", {31'b0, frame_start_o}, 32'd1);
    $display("[TB] mid-frame reset seq done");

    // Randomized stimulus against the reference model
    for (int k = 0; k < 2500; k++) begin
      hex_i       = 16'($urandom);
      raw_seg_i   = 28'($urandom);
      raw_mode_i  = 1'($urandom_range(0, 1));
      dp_i        = 4'($urandom);
      en_i        = 4'($urandom);
      blink_i     = 4'($urandom);
      bright_i    = 3'($urandom);
      upd_valid_i = ($urandom_range(0, 5) == 0);
      tick();
    end
    upd_valid_i = 1'b0;
    $display("[TB] random seq done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
